uart_transmitter: RTL
=====================

// Module: uart_transmitter
// PURPOSE
//  Serialises bytes from a ready/valid producer onto the UART TX line: 8N1, LSB first.
//  Sits inside uart_top and drives uart_tx_o; it is the transmit end of the serial link that uart_top's receiver decodes.
//  A small FIFO decouples bursts from the CPU/MMIO side.
//  Back-to-back frames are sent with no idle gap.
// PARAMETERS
//  CLOCK_FREQ   125_000_000  clk frequency in Hz
//  BAUD_RATE    115_200      line rate in bit/s
//  FIFO_DEPTH   4            bytes buffered ahead of the shift register; power of 2, >= 2
// PORTS
//  clk             in   1  system clock; all logic on posedge
//  reset           in   1  synchronous, active-high reset
//  data_in         in   8  byte to transmit
//  data_in_valid   in   1  producer has a byte on data_in
//  data_in_ready   out  1  FIFO can accept; transfer when valid && ready at posedge
//  serial_out      out  1  UART TX line, idle high
//  busy            out  1  frame in progress or FIFO non-empty
// BEHAVIOUR
//  - Reset values (cycle after reset is sampled high):
//    serial_out=1, data_in_ready=1, busy=0, FSM=IDLE, FIFO empty, counters 0.
//  - Bit timing:
//    SYMBOL_EDGE_TIME = CLOCK_FREQ/BAUD_RATE (integer division; 1085 at defaults).
//    Every bit, including start and stop, is held exactly SYMBOL_EDGE_TIME cycles.
//    A frame is 10*SYMBOL_EDGE_TIME cycles.
//  - Counter widths:
//    Baud counter is $clog2(SYMBOL_EDGE_TIME) bits, counts 0..SYMBOL_EDGE_TIME-1, then wraps.
//    Bit index is 3 bits.
//  - Handshake:
//    data_in_ready = !fifo_full; it is registered-state only, with no combinational path from the pop.
//    When the FIFO is full and a pop occurs, ready rises the cycle after the pop.
//    data_in is captured at the accepting edge; valid with ready=0 is ignored (no drop, no error).
//  - FSM states and transitions:
//    IDLE  : serial_out=1. If FIFO non-empty, pop into the shift register and go to START.
//    START : serial_out=0 for SYMBOL_EDGE_TIME cycles, then go to DATA with bit index 0.
//    DATA  : serial_out=shift[0]; at each bit end, shift right and increment the index. After bit 7, go to STOP.
//    STOP  : serial_out=1 for SYMBOL_EDGE_TIME cycles. At the end:
//            FIFO non-empty -> pop and go to START in the same cycle (no idle bit);
//            FIFO empty     -> go to IDLE.
//  - Latency: a byte accepted into an empty FIFO with the FSM in IDLE gives serial_out=0 two cycles after the accepting edge.
//  - serial_out is driven from a flop (glitch-free).
//  - Simultaneous push and pop: allowed whenever not full; the occupancy count is unchanged.
//  - busy = (state!=IDLE) || !fifo_empty.
//  - Reset mid-frame: the frame is abandoned, serial_out returns to 1 on the next cycle, and the FIFO is flushed.
//    A truncated frame on the line is acceptable; the receiver resynchronises on the next start edge.
// STRUCTURE
//  - Shared header uart_defs.vh holds:
//    SYMBOL_EDGE_TIME computation macro;
//    state encodings IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3;
//    UART_DATA_BITS=8.
//  - Sub-module sync_fifo (WIDTH=8, DEPTH=FIFO_DEPTH):
//    ports clk, reset, wr_en, din, full, rd_en, dout, empty;
//    first-word-fall-through; full/empty are registered.
//  - The FSM, baud counter, bit index and shift register stay in uart_transmitter.
// TESTING
//  1. Reset:
//     hold reset 10 cycles -> serial_out=1, data_in_ready=1, busy=0 for 100 cycles with no stimulus.
//  2. Single byte 0x5A:
//     serial_out reads 0,0,1,0,1,1,0,1,0,1.
//     Each level holds 1085 cycles, sampled mid-bit.
//     The start edge occurs 2 cycles after accept.
//     busy drops 10850 cycles after the start edge.
//  3. Burst of 6 bytes 0x01..0x06 with valid held high:
//     5 are accepted immediately (1 in the shift register, 4 in the FIFO), then ready=0.
//     Ready returns 1 cycle after frame 1 ends.
//     Six frames are sent back to back with no idle bit between them.
//  4. Loopback:
//     drive serial_out into uart_top.uart_rx_i and send 0x00, 0xFF, 0xA5, 0x3C.
//     The receiver yields the same 4 bytes in order.
//     Timeout 25000 cycles per byte flags failure.
//  5. Reset mid-frame:
//     assert reset during bit 4 of 0xC3 with 2 bytes queued.
//     serial_out=1 next cycle, FIFO empty, no further frames; the next byte after reset transmits correctly.
//  6. Valid toggling:
//     drive valid high only on odd cycles while full.
//     No byte is lost or duplicated across 8 bytes, checked against a scoreboard.

Source files
------------

// File: rtl/uart_transmitter_pkg.sv
// Shared definitions for the UART transmit path: frame states, data width,
// and the bit-period computation.
package uart_transmitter_pkg;

    localparam int unsigned UART_DATA_BITS = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    // Clock cycles per line bit (integer division, truncating).
    function automatic int unsigned symbol_edge_time(input int unsigned clock_freq,
                                                     input int unsigned baud_rate);
        return clock_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_transmitter_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with registered full/empty flags.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             r_full;
    logic             r_empty;

    logic             w_push;
    logic             w_pop;
    logic [AW:0]      w_count_next;

    assign w_push = wr_en && !r_full;
    assign w_pop  = rd_en && !r_empty;

    // Occupancy after this cycle's push/pop; simultaneous push and pop leave it unchanged.
    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + 1'b1;
            2'b01:   w_count_next = r_count - 1'b1;
            default: w_count_next = r_count;
        endcase
    end

    // Pointers, occupancy and flags; flags are derived from the next count so they are pure flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= w_count_next;
            r_full  <= (w_count_next == FULL_COUNT);
            r_empty <= (w_count_next == '0);
        end
    end

    // Storage write; contents need no reset because empty gates every read.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= din;
    end

    assign dout  = r_mem[r_rd_ptr];
    assign full  = r_full;
    assign empty = r_empty;

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: 8N1, LSB first, fed from a ready/valid port through a
// small FIFO. Back-to-back frames carry no idle bit between them.
module uart_transmitter
    import uart_transmitter_pkg::*;
#(
    parameter int unsigned CLOCK_FREQ = 125_000_000,
    parameter int unsigned BAUD_RATE  = 115_200,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       data_in_valid,
    output logic       data_in_ready,
    output logic       serial_out,
    output logic       busy
);

    localparam int unsigned SYMBOL_EDGE_TIME = symbol_edge_time(CLOCK_FREQ, BAUD_RATE);
    localparam int unsigned BAUD_W    = (SYMBOL_EDGE_TIME > 1) ? $clog2(SYMBOL_EDGE_TIME) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(SYMBOL_EDGE_TIME - 1);
    localparam logic [2:0]        LAST_BIT  = 3'(UART_DATA_BITS - 1);

    tx_state_t                 r_state;
    tx_state_t                 w_state_next;
    logic [BAUD_W-1:0]         r_baud_cnt;
    logic [BAUD_W-1:0]         w_baud_cnt_next;
    logic [2:0]                r_bit_idx;
    logic [2:0]                w_bit_idx_next;
    logic [UART_DATA_BITS-1:0] r_shift;
    logic [UART_DATA_BITS-1:0] w_shift_next;
    logic                      r_serial;
    logic                      r_line_active;
    logic                      w_line;
    logic                      w_bit_end;

    logic                      w_fifo_full;
    logic                      w_fifo_empty;
    logic                      w_fifo_pop;
    logic [UART_DATA_BITS-1:0] w_fifo_dout;

    sync_fifo #(
        .WIDTH (UART_DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .wr_en (data_in_valid),
        .din   (data_in),
        .full  (w_fifo_full),
        .rd_en (w_fifo_pop),
        .dout  (w_fifo_dout),
        .empty (w_fifo_empty)
    );

    assign w_bit_end = (r_baud_cnt == BAUD_LAST);

    // Next-state, bit timing, shift and FIFO pop; w_line is the level for the current state.
    always_comb begin
        w_state_next    = r_state;
        w_baud_cnt_next = r_baud_cnt;
        w_bit_idx_next  = r_bit_idx;
        w_shift_next    = r_shift;
        w_fifo_pop      = 1'b0;
        w_line          = 1'b1;

        if (r_state != IDLE) begin
            w_baud_cnt_next = w_bit_end ? '0 : r_baud_cnt + 1'b1;
        end

        case (r_state)
            IDLE: begin
                w_baud_cnt_next = '0;
                if (!w_fifo_empty) begin
                    w_fifo_pop   = 1'b1;
                    w_shift_next = w_fifo_dout;
                    w_state_next = START;
                end
            end
            START: begin
                w_line = 1'b0;
                if (w_bit_end) begin
                    w_bit_idx_next = '0;
                    w_state_next   = DATA;
                end
            end
            DATA: begin
                w_line = r_shift[0];
                if (w_bit_end) begin
                    w_shift_next   = {1'b0, r_shift[UART_DATA_BITS-1:1]};
                    w_bit_idx_next = r_bit_idx + 1'b1;
                    if (r_bit_idx == LAST_BIT) w_state_next = STOP;
                end
            end
            STOP: begin
                w_line = 1'b1;
                if (w_bit_end) begin
                    if (!w_fifo_empty) begin
                        w_fifo_pop   = 1'b1;
                        w_shift_next = w_fifo_dout;
                        w_state_next = START;
                    end else begin
                        w_state_next = IDLE;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // State, counters, shift register and the glitch-free line flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_baud_cnt    <= '0;
            r_bit_idx     <= '0;
            r_shift       <= '0;
            r_serial      <= 1'b1;
            r_line_active <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_baud_cnt    <= w_baud_cnt_next;
            r_bit_idx     <= w_bit_idx_next;
            r_shift       <= w_shift_next;
            r_serial      <= w_line;
            r_line_active <= (r_state != IDLE);
        end
    end

    // The line flop lags the FSM by one cycle; r_line_active keeps busy high
    // until the final stop-bit cycle has actually left serial_out.
    assign busy          = (r_state != IDLE) || !w_fifo_empty || r_line_active;
    assign data_in_ready = !w_fifo_full;
    assign serial_out    = r_serial;

endmodule
